// File: rtl/reaction_pkg.sv
// Shared encodings and helpers for the reaction-time sequencer.
// State codes are visible to the HPS through state_o.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    WAIT = 3'd2,
    STIM = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int MS_W = 14;

  // Fibonacci taps 16,14,13,11 as a bit mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [MS_W-1:0] sat_inc(
    input logic [MS_W-1:0] v,
    input logic [MS_W-1:0] lim
  );
    return (v >= lim) ? lim : v + MS_W'(1);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler with a restart input.
// clear marks the first cycle of a state; that cycle counts as zero.
module ms_tick_gen #(
  parameter int DIV = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic ms_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_eff;

  assign cnt_eff = clear ? '0 : cnt;
  assign ms_tick = (cnt_eff == CW'(DIV - 1));

  // count 0..DIV-1, wrap on the tick
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (ms_tick)
      cnt <= '0;
    else
      cnt <= cnt_eff + CW'(1);
  end

endmodule

// File: rtl/reaction_sequencer.sv
// One reaction-time trial: release, random wait, stimulus, timed press.
// All outputs are registered; state_o mirrors the FSM state.
module reaction_sequencer
  import reaction_pkg::*;
#(
  parameter int          CLK_FREQ_HZ  = 50_000_000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 10,
  parameter int          MAX_MS       = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            button_n,
  output logic            stim_led,
  output logic            busy,
  output logic [MS_W-1:0] result_ms,
  output logic            result_valid,
  output logic            too_early,
  output logic            timeout,
  output logic [2:0]      state_o
);

  localparam int DIV = CLK_FREQ_HZ / 1000;
  localparam logic [MS_W-1:0] MAX_V = MS_W'(MAX_MS);

  state_t          state;
  logic [15:0]     lfsr;
  logic [2:0]      sync;
  logic            press;
  logic            released;
  logic [MS_W-1:0] ms_cnt;
  logic [MS_W-1:0] ms_next;
  logic [MS_W-1:0] delay_ms;
  logic            clr;
  logic            ms_tick;

  assign state_o  = state;
  assign released = sync[1];
  assign ms_next  = sat_inc(ms_cnt, MAX_V);

  ms_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (clr),
    .ms_tick(ms_tick)
  );

  // free-running LFSR; a nonzero seed keeps it off the all-zero lockup
  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  // two-flop synchroniser plus a history flop for the falling-edge press
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 3'b111;
      press <= 1'b0;
    end else begin
      sync  <= {sync[1:0], button_n};
      press <= sync[2] & ~sync[1];
    end
  end

  // trial FSM; clr flags the first cycle of every newly entered state
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      stim_led     <= 1'b0;
      busy         <= 1'b0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      too_early    <= 1'b0;
      timeout      <= 1'b0;
      ms_cnt       <= '0;
      delay_ms     <= '0;
      clr          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      clr          <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        stim_led <= 1'b0;
        busy     <= 1'b0;
        clr      <= 1'b1;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (start) begin
              state     <= ARM;
              busy      <= 1'b1;
              too_early <= 1'b0;
              timeout   <= 1'b0;
              delay_ms  <= MS_W'(MIN_DELAY_MS)
                         + MS_W'(lfsr[RAND_BITS-1:0]);
              clr       <= 1'b1;
            end
          end
          ARM: begin
            if (released) begin
              state  <= WAIT;
              ms_cnt <= '0;
              clr    <= 1'b1;
            end
          end
          WAIT: begin
            if (press) begin
              state        <= DONE;
              busy         <= 1'b0;
              too_early    <= 1'b1;
              result_ms    <= '0;
              result_valid <= 1'b1;
              clr          <= 1'b1;
            end else if (ms_tick) begin
              if (ms_cnt == delay_ms - MS_W'(1)) begin
                state    <= STIM;
                stim_led <= 1'b1;
                ms_cnt   <= '0;
                clr      <= 1'b1;
              end else begin
                ms_cnt <= ms_next;
              end
            end
          end
          STIM: begin
            if (press) begin
              state        <= DONE;
              stim_led     <= 1'b0;
              busy         <= 1'b0;
              result_ms    <= ms_cnt;
              result_valid <= 1'b1;
              clr          <= 1'b1;
            end else if (ms_tick) begin
              ms_cnt <= ms_next;
              if (ms_next >= MAX_V) begin
                state        <= DONE;
                stim_led     <= 1'b0;
                busy         <= 1'b0;
                timeout      <= 1'b1;
                result_ms    <= MAX_V;
                result_valid <= 1'b1;
                clr          <= 1'b1;
              end
            end
          end
          default: begin
            state    <= IDLE;
            stim_led <= 1'b0;
            busy     <= 1'b0;
            clr      <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_sequencer.sv
// Scoreboard bench for reaction_sequencer: directed trials, results
// popped and compared by an independent monitor on result_valid.
module tb_reaction_sequencer;
  import reaction_pkg::*;

  localparam int MAXMS = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        button_n = 1'b1;
  logic        stim_led;
  logic        busy;
  logic [13:0] result_ms;
  logic        result_valid;
  logic        too_early;
  logic        timeout;
  logic [2:0]  state_o;

  typedef struct packed {
    logic [13:0] ms;
    logic        te;
    logic        to;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int stim_cnt = 0;
  int lfsr_zero = 0;

  reaction_sequencer #(
    .CLK_FREQ_HZ (10_000),
    .MIN_DELAY_MS(5),
    .RAND_BITS   (2),
    .MAX_MS      (MAXMS),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .button_n    (button_n),
    .stim_led    (stim_led),
    .busy        (busy),
    .result_ms   (result_ms),
    .result_valid(result_valid),
    .too_early   (too_early),
    .timeout     (timeout),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // monitor: every result_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && result_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got ms=%0d te=%0d to=%0d want none",
                 result_ms, too_early, timeout);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (result_ms !== e.ms || too_early !== e.te || timeout !== e.to) begin
          bad++;
          $display("FAIL result: got ms=%0d te=%0d to=%0d want ms=%0d te=%0d to=%0d",
                   result_ms, too_early, timeout, e.ms, e.te, e.to);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (stim_led) stim_cnt++;
    if (!reset && dut.lfsr == 16'h0) lfsr_zero++;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim,
                            input string nm);
    int n = 0;
    while (state_o !== s && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(state_o), int'(s));
  endtask

  task automatic wait_stim(input int lim, input string nm);
    int n = 0;
    while (stim_led !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(stim_led), 1);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_stim"}, int'(stim_led), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_ms"}, int'(result_ms), 0);
    chk({nm, "_valid"}, int'(result_valid), 0);
    chk({nm, "_early"}, int'(too_early), 0);
    chk({nm, "_tmo"}, int'(timeout), 0);
    chk({nm, "_state"}, int'(state_o), int'(IDLE));
  endtask

  initial begin
    int n;
    int base;
    exp_t e;

    repeat (3) @(negedge clk);
    check_reset("rst");
    reset = 1'b0;

    // 1: press 37 ms after stimulus (pin at cycle 372 -> press at 375)
    pulse_start();
    chk("t1_busy", int'(busy), 1);
    e = '{ms: 14'd37, te: 1'b0, to: 1'b0};
    q.push_back(e);
    wait_stim(200, "t1_stim");
    repeat (372) @(negedge clk);
    button_n = 1'b0;
    wait_state(DONE, 20, "t1_done");
    chk("t1_led_off", int'(stim_led), 0);
    chk("t1_busy_off", int'(busy), 0);
    repeat (5) @(negedge clk);
    button_n = 1'b1;
    repeat (5) @(negedge clk);

    // 2: press during WAIT
    base = stim_cnt;
    pulse_start();
    wait_state(WAIT, 20, "t2_wait");
    repeat (10) @(negedge clk);
    button_n = 1'b0;
    e = '{ms: 14'd0, te: 1'b1, to: 1'b0};
    q.push_back(e);
    wait_state(DONE, 20, "t2_done");
    chk("t2_no_stim", stim_cnt - base, 0);
    repeat (3) @(negedge clk);
    button_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t2_hold_done", int'(state_o), int'(DONE));

    // 3: no press -> timeout after exactly MAXMS ms of stimulus
    pulse_start();
    e = '{ms: 14'(MAXMS), te: 1'b0, to: 1'b1};
    q.push_back(e);
    wait_stim(200, "t3_stim");
    n = 0;
    while (stim_led === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t3_stim_cycles", n, MAXMS * 10);
    chk("t3_state", int'(state_o), int'(DONE));
    repeat (2) @(negedge clk);
    chk("t3_tmo_sticky", int'(timeout), 1);

    // 4: button held at start; start while busy ignored
    button_n = 1'b0;
    repeat (5) @(negedge clk);
    pulse_start();
    chk("t4_tmo_clr", int'(timeout), 0);
    repeat (100) @(negedge clk);
    chk("t4_arm", int'(state_o), int'(ARM));
    pulse_start();
    chk("t4_arm_again", int'(state_o), int'(ARM));
    button_n = 1'b1;
    e = '{ms: 14'd5, te: 1'b0, to: 1'b0};
    q.push_back(e);
    wait_stim(200, "t4_stim");
    repeat (52) @(negedge clk);
    button_n = 1'b0;
    wait_state(DONE, 20, "t4_done");
    button_n = 1'b1;
    repeat (5) @(negedge clk);

    // 5a: abort in STIM
    pulse_start();
    wait_stim(200, "t5_stim");
    pulse_abort();
    chk("t5_state", int'(state_o), int'(IDLE));
    chk("t5_led", int'(stim_led), 0);
    chk("t5_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    chk("t5_ms_held", int'(result_ms), 5);

    // 5b: start and abort together
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t5b_state", int'(state_o), int'(IDLE));
    chk("t5b_busy", int'(busy), 0);
    repeat (5) @(negedge clk);

    // 6: reset in STIM
    pulse_start();
    wait_stim(200, "t6_stim");
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset("t6");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // delay range over 16 trials: WAIT lasts delay_ms * 10 cycles
    for (int i = 0; i < 16; i++) begin
      repeat (i) @(negedge clk);
      pulse_start();
      wait_state(WAIT, 20, "dly_wait");
      n = 0;
      while (state_o === WAIT && n < 200) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (n < 50 || n > 80 || (n % 10) != 0) begin
        bad++;
        $display("FAIL delay[%0d]: got %0d cycles want 50..80 step 10",
                 i, n);
      end
      chk("dly_stim", int'(state_o), int'(STIM));
      pulse_abort();
    end

    repeat (5) @(negedge clk);
    chk("lfsr_nonzero", lfsr_zero, 0);
    chk("sb_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
